ling_add32_issue_stage: RTL and testbench

- Sequential wrapper around the combinational 32-bit sparse Ling adder.
- Accepts operand pairs on a valid/ready handshake and registers them onto the adder inputs.
- Holds the operands stable for a programmable multicycle settle window, then captures the adder sum into an output register.
- Derives carry-out and signed overflow, and presents the result on a second valid/ready handshake to the downstream consumer.

---
 rtl/ling_add32_issue_stage.sv | 140 ++++++++++++++
 tb/tb_ling_add32_issue_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ling_add32_issue_stage.sv
// ling_add32_issue_stage
//   Sequential issue stage wrapped around an external combinational 32-bit
//   Ling adder. Operand pairs are accepted on a valid/ready handshake and
//   registered onto the adder inputs. The inputs are held for SETTLE_CYC
//   cycles, then the sum, carry-out and signed overflow are captured and
//   offered downstream on a second valid/ready handshake.
//
//   Optional feature macro: LING_ADD_SELFCHECK_EN
//     adds the sticky output chk_err, which is set when the adder sum
//     disagrees with a behavioural 32-bit reference sum at capture time.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake; in_a, in_b operands
//   add_a, add_b        registered operands driving the adder
//   add_sum             adder result (combinational from add_a/add_b)
//   out_valid/out_ready result handshake
//   out_sum, out_cout, out_ovf   captured sum, carry out, signed overflow
//   chk_err             (LING_ADD_SELFCHECK_EN only) sticky adder check flag

module ling_add32_issue_stage #(
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_sum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        out_cout,
  output logic        out_ovf
`ifdef LING_ADD_SELFCHECK_EN
  ,
  output logic        chk_err
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             load, capture, release_out;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    load        = 1'b0;
    capture     = 1'b0;
    release_out = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // Accepting the next pair in the same cycle the result leaves keeps
        // the stream bubble-free apart from the settle window.
        in_ready = out_ready;
        if (out_ready) begin
          release_out = 1'b1;
          if (in_valid) begin
            load      = 1'b1;
            state_nxt = SETTLE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      add_a <= '0;
      add_b <= '0;
    end else if (load) begin
      cnt   <= CNT_LOAD;
      add_a <= in_a;
      add_b <= in_b;
    end else if (state == SETTLE && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (capture) begin
        out_sum   <= add_sum;
        // Carry out of bit 31 recovered from the top-bit operands and sum.
        out_cout  <= (add_a[31] & add_b[31]) |
                     ((add_a[31] ^ add_b[31]) & ~add_sum[31]);
        out_ovf   <= (add_a[31] == add_b[31]) & (add_sum[31] != add_a[31]);
        out_valid <= 1'b1;
      end else if (release_out) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef LING_ADD_SELFCHECK_EN
  logic [31:0] ref_sum;
  assign ref_sum = add_a + add_b;

  always_ff @(posedge clk) begin
    if (rst)          chk_err <= 1'b0;
    else if (capture) chk_err <= chk_err | (add_sum != ref_sum);
  end
`endif

endmodule

// File: tb/tb_ling_add32_issue_stage.sv
// Testbench for ling_add32_issue_stage: one instance with SETTLE_CYC=1 for
// the directed single-operation tests and one with SETTLE_CYC=3 for the
// back-to-back stream. The adder is modelled as a behavioural sum.

module tb_ling_add32_issue_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // SETTLE_CYC = 1 instance
  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_cout1, out_ovf1;
  logic [31:0] in_a1, in_b1, add_a1, add_b1, add_sum1, out_sum1;
  logic        flip1;
  assign add_sum1 = (add_a1 + add_b1) ^ {31'h0, flip1};

  // SETTLE_CYC = 3 instance
  logic        in_valid3, in_ready3, out_valid3, out_ready3, out_cout3, out_ovf3;
  logic [31:0] in_a3, in_b3, add_a3, add_b3, add_sum3, out_sum3;
  assign add_sum3 = add_a3 + add_b3;

`ifdef LING_ADD_SELFCHECK_EN
  logic chk_err1, chk_err3;
`endif

  ling_add32_issue_stage #(.SETTLE_CYC(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .add_a(add_a1), .add_b(add_b1),
    .add_sum(add_sum1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_cout(out_cout1), .out_ovf(out_ovf1)
`ifdef LING_ADD_SELFCHECK_EN
    , .chk_err(chk_err1)
`endif
  );

  ling_add32_issue_stage #(.SETTLE_CYC(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_a(in_a3), .in_b(in_b3), .add_a(add_a3), .add_b(add_b3),
    .add_sum(add_sum3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_sum(out_sum3), .out_cout(out_cout3), .out_ovf(out_ovf3)
`ifdef LING_ADD_SELFCHECK_EN
    , .chk_err(chk_err3)
`endif
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one pair into dut1 (out_ready1 must be 1) and check the full
  // timeline: accept, one settle cycle, one valid cycle, then idle.
  task automatic run_op1(input logic [31:0] a, input logic [31:0] b, input bit chk);
    logic [32:0] e;
    logic        e_ovf;
    int          n;
    e     = {1'b0, a} + {1'b0, b};
    e_ovf = (a[31] == b[31]) && (e[31] != a[31]);
    in_a1 = a; in_b1 = b; in_valid1 = 1'b1;
    n = 0;
    while (!in_ready1 && n < 20) begin tick(); n++; end
    checks++;
    if (in_ready1 !== 1'b1) begin
      errors++; $display("FAIL op_accept: in_ready=%b required 1", in_ready1);
    end
    tick();
    in_valid1 = 1'b0;
    if (chk) begin
      checks++;
      if (out_valid1 !== 1'b0 || add_a1 !== a || add_b1 !== b) begin
        errors++;
        $display("FAIL op_settle: out_valid=%b add_a=%h add_b=%h required 0 %h %h",
                 out_valid1, add_a1, add_b1, a, b);
      end
    end
    tick();
    if (chk) begin
      checks++;
      if (out_valid1 !== 1'b1 || out_sum1 !== e[31:0] || out_cout1 !== e[32] || out_ovf1 !== e_ovf) begin
        errors++;
        $display("FAIL op_result %h+%h: valid=%b sum=%h cout=%b ovf=%b required 1 %h %b %b",
                 a, b, out_valid1, out_sum1, out_cout1, out_ovf1, 1'b1, e[31:0], e[32], e_ovf);
      end
    end
    tick();
    if (chk) begin
      checks++;
      if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
        errors++;
        $display("FAIL op_release: out_valid=%b in_ready=%b required 0 1", out_valid1, in_ready1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    rst = 1'b0;
    checks++;
    if (out_valid1 !== 1'b0 || add_a1 !== 32'h0 || add_b1 !== 32'h0 || out_sum1 !== 32'h0 ||
        out_cout1 !== 1'b0 || out_ovf1 !== 1'b0 || in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b a=%h b=%h sum=%h cout=%b ovf=%b rdy=%b required 0 0 0 0 0 0 1",
               out_valid1, add_a1, add_b1, out_sum1, out_cout1, out_ovf1, in_ready1);
    end
    // Reset while dut1 is in SETTLE: the operation must vanish.
    in_a1 = 32'h1234; in_b1 = 32'h1; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    rst = 1'b1; tick(); tick();
    rst = 1'b0;
    checks++;
    if (out_valid1 !== 1'b0 || add_a1 !== 32'h0 || add_b1 !== 32'h0 || in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_settle: valid=%b a=%h b=%h rdy=%b required 0 0 0 1",
               out_valid1, add_a1, add_b1, in_ready1);
    end
    tick(); tick();
    checks++;
    if (out_valid1 !== 1'b0) begin
      errors++; $display("FAIL reset_no_result: out_valid=%b required 0", out_valid1);
    end
  endtask

  task automatic test_basic();
    out_ready1 = 1'b1;
    run_op1(32'h0000_0005, 32'h0000_0007, 1'b1);
    run_op1(32'h0000_1000, 32'h0000_0234, 1'b1);
  endtask

  task automatic test_carry_ovf();
    run_op1(32'hFFFF_FFFF, 32'h0000_0001, 1'b1); // sum 0, cout 1, ovf 0
    run_op1(32'h7FFF_FFFF, 32'h0000_0001, 1'b1); // sum 8000_0000, ovf 1
    run_op1(32'h8000_0000, 32'h8000_0000, 1'b1); // sum 0, cout 1, ovf 1
    run_op1(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1); // -2 + -1, cout 1, no ovf
  endtask

  task automatic test_backpressure();
    int n;
    out_ready1 = 1'b0;
    in_a1 = 32'h1; in_b1 = 32'h2; in_valid1 = 1'b1;
    tick();                      // accepted from IDLE
    in_a1 = 32'h10; in_b1 = 32'h20;  // second pair pending
    tick();                      // captured, now HOLD
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (in_ready1 !== 1'b0 || out_valid1 !== 1'b1 || out_sum1 !== 32'h3 || add_a1 !== 32'h1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: rdy=%b valid=%b sum=%h add_a=%h required 0 1 3 1",
                 i, in_ready1, out_valid1, out_sum1, add_a1);
      end
      tick();
    end
    out_ready1 = 1'b1;
    #1;
    checks++;
    if (in_ready1 !== 1'b1) begin
      errors++; $display("FAIL bp_passthru: in_ready=%b required 1", in_ready1);
    end
    tick();
    in_valid1 = 1'b0;
    checks++;
    if (out_valid1 !== 1'b0 || add_a1 !== 32'h10 || add_b1 !== 32'h20) begin
      errors++;
      $display("FAIL bp_second_load: valid=%b a=%h b=%h required 0 10 20", out_valid1, add_a1, add_b1);
    end
    n = 0;
    while (!out_valid1 && n < 10) begin tick(); n++; end
    checks++;
    if (out_valid1 !== 1'b1 || out_sum1 !== 32'h30) begin
      errors++; $display("FAIL bp_second_result: valid=%b sum=%h required 1 30", out_valid1, out_sum1);
    end
    tick();
    tick();
    checks++;
    if (out_valid1 !== 1'b0) begin
      errors++; $display("FAIL bp_no_dup: out_valid=%b required 0", out_valid1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va[16], vb[16];
    int idx, k, last, cyc;
    bit acc;
    for (int i = 0; i < 16; i++) begin va[i] = $urandom; vb[i] = $urandom; end
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0002;
    out_ready3 = 1'b1;
    idx = 0; k = 0; last = -1; acc = 1'b0;
    for (cyc = 0; cyc < 200 && k < 16; cyc++) begin
      if (out_valid3) begin
        checks++;
        if (out_sum3 !== va[k] + vb[k]) begin
          errors++; $display("FAIL b2b_sum[%0d]: got %h required %h", k, out_sum3, va[k] + vb[k]);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 4) begin
            errors++; $display("FAIL b2b_spacing[%0d]: got %0d cycles required 4", k, cyc - last);
          end
        end
        last = cyc;
        k++;
      end
      if (acc) idx++;
      in_valid3 = (idx < 16);
      in_a3 = va[idx % 16]; in_b3 = vb[idx % 16];
      #0;
      acc = in_valid3 && in_ready3;
      tick();
    end
    in_valid3 = 1'b0;
    checks++;
    if (k != 16) begin
      errors++; $display("FAIL b2b_count: got %0d results required 16", k);
    end
  endtask

`ifdef LING_ADD_SELFCHECK_EN
  task automatic test_selfcheck();
    out_ready1 = 1'b1;
    for (int i = 0; i < 1000; i++) run_op1($urandom, $urandom, 1'b1);
    checks++;
    if (chk_err1 !== 1'b0) begin
      errors++; $display("FAIL chk_clean: chk_err=%b required 0", chk_err1);
    end
    flip1 = 1'b1;
    run_op1(32'h5, 32'h6, 1'b0);
    flip1 = 1'b0;
    checks++;
    if (chk_err1 !== 1'b1) begin
      errors++; $display("FAIL chk_set: chk_err=%b required 1", chk_err1);
    end
    run_op1(32'h9, 32'h9, 1'b1);
    checks++;
    if (chk_err1 !== 1'b1) begin
      errors++; $display("FAIL chk_sticky: chk_err=%b required 1", chk_err1);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (chk_err1 !== 1'b0) begin
      errors++; $display("FAIL chk_reset: chk_err=%b required 0", chk_err1);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; out_ready1 = 1'b1; flip1 = 1'b0;
    in_valid3 = 1'b0; in_a3 = '0; in_b3 = '0; out_ready3 = 1'b1;
    test_reset();
    test_basic();
    test_carry_ovf();
    test_backpressure();
    test_back_to_back();
`ifdef LING_ADD_SELFCHECK_EN
    test_selfcheck();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
